// File: rtl/bsg_wormhole_packet_sender.sv
// Transmit-side wormhole packetizer.
// Emits one header flit (cord, len, extra bits), then exactly len body flits,
// through a single output register on a ready/valid link.
module bsg_wormhole_packet_sender #(
    parameter int flit_width_p = 32,
    parameter int cord_width_p = 5,
    parameter int len_width_p  = 4,
    localparam int hdr_data_width_lp = flit_width_p - cord_width_p - len_width_p
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,

    input  logic                         pkt_v_i,
    input  logic [cord_width_p-1:0]      pkt_cord_i,
    input  logic [len_width_p-1:0]       pkt_len_i,
    input  logic [hdr_data_width_lp-1:0] pkt_hdr_data_i,
    output logic                         pkt_ready_o,

    input  logic                         data_v_i,
    input  logic [flit_width_p-1:0]      data_i,
    output logic                         data_ready_o,

    output logic                         link_v_o,
    output logic [flit_width_p-1:0]      link_data_o,
    input  logic                         link_ready_i,

    output logic                         busy_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BODY = 1'b1;

    logic [0:0]              r_state;
    logic [len_width_p-1:0]  r_ctr;
    logic                    r_link_v;
    logic [flit_width_p-1:0] r_link_data;

    logic                    w_slot_free;
    logic                    w_pkt_acc;
    logic                    w_data_acc;
    logic                    w_last_word;
    logic [flit_width_p-1:0] w_hdr_flit;

    // The output register can take a new flit when it is empty or draining this cycle.
    assign w_slot_free  = ~r_link_v | link_ready_i;

    assign pkt_ready_o  = (r_state == ST_IDLE) & w_slot_free;
    assign data_ready_o = (r_state == ST_BODY) & w_slot_free;
    assign busy_o       = (r_state == ST_BODY);

    assign w_pkt_acc    = pkt_v_i  & pkt_ready_o;
    assign w_data_acc   = data_v_i & data_ready_o;
    assign w_last_word  = (r_ctr == len_width_p'(1));

    assign w_hdr_flit   = {pkt_hdr_data_i, pkt_len_i, pkt_cord_i};

    assign link_v_o     = r_link_v;
    assign link_data_o  = r_link_data;

    // Packet FSM: a header with nonzero length opens a body of r_ctr words.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= ST_IDLE;
            r_ctr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pkt_acc && (pkt_len_i != '0)) begin
                        r_state <= ST_BODY;
                        r_ctr   <= pkt_len_i;
                    end
                end
                ST_BODY: begin
                    // r_ctr is at least 1 here, so the decrement cannot wrap.
                    if (w_data_acc) begin
                        r_ctr <= r_ctr - len_width_p'(1);
                        if (w_last_word) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ctr   <= '0;
                end
            endcase
        end
    end

    // One-entry output register: load on accept, clear when drained, hold when stalled.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_link_v    <= 1'b0;
            r_link_data <= '0;
        end else if (w_pkt_acc) begin
            r_link_v    <= 1'b1;
            r_link_data <= w_hdr_flit;
        end else if (w_data_acc) begin
            r_link_v    <= 1'b1;
            r_link_data <= data_i;
        end else if (w_slot_free) begin
            r_link_v    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bsg_wormhole_packet_sender.sv
// Self-checking bench for bsg_wormhole_packet_sender (default parameters).
module tb_bsg_wormhole_packet_sender;

    typedef struct packed {
        logic [4:0]  cord;
        logic [3:0]  len;
        logic [22:0] hdr;
    } pkt_t;

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic        pkt_v_i;
    logic [4:0]  pkt_cord_i;
    logic [3:0]  pkt_len_i;
    logic [22:0] pkt_hdr_data_i;
    logic        pkt_ready_o;
    logic        data_v_i;
    logic [31:0] data_i;
    logic        data_ready_o;
    logic        link_v_o;
    logic [31:0] link_data_o;
    logic        link_ready_i;
    logic        busy_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_rx = 0;
    int rx_cyc[$];
    int last_hdr_edge = 0;
    int rcv_cnt = 0;
    int expire_idx = -1;
    bit busy_seen = 0;
    bit rand_mode = 0;
    bit prev_stall = 0;
    logic [31:0] prev_data = '0;

    pkt_t        pkt_q[$];
    logic [31:0] data_q[$];
    logic [31:0] sb[$];

    bsg_wormhole_packet_sender dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n_i),
        .pkt_v_i        (pkt_v_i),
        .pkt_cord_i     (pkt_cord_i),
        .pkt_len_i      (pkt_len_i),
        .pkt_hdr_data_i (pkt_hdr_data_i),
        .pkt_ready_o    (pkt_ready_o),
        .data_v_i       (data_v_i),
        .data_i         (data_i),
        .data_ready_o   (data_ready_o),
        .link_v_o       (link_v_o),
        .link_data_o    (link_data_o),
        .link_ready_i   (link_ready_i),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Source driver: decides accepts at negedge, advances queues just after posedge.
    always begin
        bit ap, ad;
        @(negedge clk);
        ap = reset_n_i && pkt_v_i && pkt_ready_o;
        ad = reset_n_i && data_v_i && data_ready_o;
        @(posedge clk);
        #1;
        if (ap && pkt_q.size() > 0) begin
            void'(pkt_q.pop_front());
            last_hdr_edge = cyc;
        end
        if (ad && data_q.size() > 0) void'(data_q.pop_front());
        if (rand_mode) link_ready_i = 1'($urandom_range(0, 1));
        pkt_v_i = (pkt_q.size() > 0);
        if (pkt_q.size() > 0) begin
            pkt_cord_i     = pkt_q[0].cord;
            pkt_len_i      = pkt_q[0].len;
            pkt_hdr_data_i = pkt_q[0].hdr;
        end
        data_v_i = (data_q.size() > 0) && (!rand_mode || ($urandom_range(0, 3) != 0));
        data_i   = (data_q.size() > 0) ? data_q[0] : 32'h0;
    end

    // Link monitor: scoreboard compare, hold-under-stall check, reference receiver counter.
    always @(negedge clk) begin
        logic [31:0] exp_flit;
        if (!reset_n_i) begin
            rcv_cnt    = 0;
            prev_stall = 0;
        end else begin
            if (busy_o) busy_seen = 1;
            if (prev_stall) begin
                checks++;
                if (link_v_o !== 1'b1 || link_data_o !== prev_data) begin
                    errors++;
                    $display("FAIL hold: v=%0b data=%h required v=1 data=%h", link_v_o, link_data_o, prev_data);
                end
            end
            prev_stall = link_v_o && !link_ready_i;
            prev_data  = link_data_o;
            if (link_v_o && link_ready_i) begin
                n_rx++;
                rx_cyc.push_back(cyc + 1);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL flit: unexpected flit %h, none required", link_data_o);
                end else begin
                    exp_flit = sb.pop_front();
                    if (link_data_o !== exp_flit) begin
                        errors++;
                        $display("FAIL flit: got %h required %h", link_data_o, exp_flit);
                    end
                end
                if (rcv_cnt == 0) begin
                    rcv_cnt = int'(link_data_o[8:5]);
                    if (rcv_cnt == 0) expire_idx = n_rx;
                end else begin
                    rcv_cnt--;
                    if (rcv_cnt == 0) expire_idx = n_rx;
                end
            end
        end
    end

    task automatic send_pkt(input logic [4:0] c, input logic [3:0] l, input logic [22:0] h,
                            input logic [31:0] base);
        pkt_t p;
        p.cord = c; p.len = l; p.hdr = h;
        pkt_q.push_back(p);
        sb.push_back({h, l, c});
        for (int i = 0; i < int'(l); i++) begin
            data_q.push_back(base + 32'(i));
            sb.push_back(base + 32'(i));
        end
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (n_rx >= n) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n_i = 1'b0;
        #2;
        checks++;
        if (link_v_o !== 1'b0 || link_data_o !== 32'h0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: v=%0b data=%h busy=%0b required 0 0 0", link_v_o, link_data_o, busy_o);
        end
        checks++;
        if (pkt_ready_o !== 1'b1 || data_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: pkt_ready=%0b data_ready=%0b required 1 0", pkt_ready_o, data_ready_o);
        end
        #10 reset_n_i = 1'b1;
    endtask

    task automatic test_basic;
        int n0;
        bit ok;
        n0 = n_rx;
        send_pkt(5'd3, 4'd2, 23'h0, 32'hA);
        wait_rx(n0 + 3, 50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_timeout: got %0d flits required %0d", n_rx - n0, 3);
        end else begin
            checks++;
            if (rx_cyc[n0 + 2] - rx_cyc[n0] !== 2) begin
                errors++;
                $display("FAIL basic_consecutive: span %0d required 2", rx_cyc[n0 + 2] - rx_cyc[n0]);
            end
            checks++;
            if (rx_cyc[n0] !== last_hdr_edge + 1) begin
                errors++;
                $display("FAIL basic_latency: edge %0d required %0d", rx_cyc[n0], last_hdr_edge + 1);
            end
        end
        @(posedge clk);
        #2;
        checks++;
        if (busy_o !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL basic_idle: busy=%0b pending=%0d required 0 0", busy_o, sb.size());
        end
    endtask

    task automatic test_header_only;
        int n0;
        bit ok;
        n0 = n_rx;
        busy_seen = 0;
        send_pkt(5'd7, 4'd0, 23'h12345, 32'h0);
        wait_rx(n0 + 1, 50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL hdr_only_timeout: got %0d flits required 1", n_rx - n0);
        end
        checks++;
        if (pkt_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL hdr_only_ready: pkt_ready=%0b required 1", pkt_ready_o);
        end
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (busy_seen !== 1'b0 || n_rx != n0 + 1) begin
            errors++;
            $display("FAIL hdr_only_busy: busy_seen=%0b flits=%0d required 0 1", busy_seen, n_rx - n0);
        end
    endtask

    task automatic test_backpressure;
        int n0;
        bit ok;
        n0 = n_rx;
        send_pkt(5'd9, 4'd3, 23'h7, 32'h300);
        wait_rx(n0 + 2, 50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_start_timeout: got %0d flits required 2", n_rx - n0);
        end
        @(posedge clk);
        #2 link_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (link_v_o !== 1'b1 || link_data_o !== 32'h301 || data_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall: v=%0b data=%h data_ready=%0b required 1 %h 0",
                         link_v_o, link_data_o, data_ready_o, 32'h301);
            end
        end
        @(posedge clk);
        #2 link_ready_i = 1'b1;
        wait_rx(n0 + 4, 50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_end_timeout: got %0d flits required 4", n_rx - n0);
        end
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (n_rx != n0 + 4 || sb.size() != 0) begin
            errors++;
            $display("FAIL bp_count: flits=%0d pending=%0d required 4 0", n_rx - n0, sb.size());
        end
    endtask

    task automatic test_back_to_back;
        int n0;
        bit ok;
        n0 = n_rx;
        send_pkt(5'd1, 4'd1, 23'h11, 32'h100);
        send_pkt(5'd2, 4'd1, 23'h22, 32'h200);
        wait_rx(n0 + 4, 50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d flits required 4", n_rx - n0);
        end else begin
            checks++;
            if (rx_cyc[n0 + 3] - rx_cyc[n0] !== 3) begin
                errors++;
                $display("FAIL b2b_consecutive: span %0d required 3", rx_cyc[n0 + 3] - rx_cyc[n0]);
            end
        end
    endtask

    task automatic test_max_len;
        int n0;
        bit ok;
        n0 = n_rx;
        expire_idx = -1;
        rand_mode = 1;
        send_pkt(5'd31, 4'd15, 23'h5A5A5, 32'h1000);
        wait_rx(n0 + 16, 3000, ok);
        rand_mode = 0;
        @(posedge clk);
        #2 link_ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (!ok || n_rx != n0 + 16) begin
            errors++;
            $display("FAIL max_count: flits=%0d required 16", n_rx - n0);
        end
        checks++;
        if (expire_idx != n0 + 16 || rcv_cnt != 0) begin
            errors++;
            $display("FAIL max_expire: at flit %0d cnt %0d required %0d 0", expire_idx - n0, rcv_cnt, 16);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL max_pending: %0d required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid;
        int n0;
        bit ok;
        n0 = n_rx;
        send_pkt(5'd4, 4'd5, 23'h3, 32'h500);
        wait_rx(n0 + 3, 50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_mid_timeout: got %0d flits required 3", n_rx - n0);
        end
        @(posedge clk);
        #3;
        reset_n_i = 1'b0;
        pkt_q.delete();
        data_q.delete();
        sb.delete();
        pkt_v_i  = 1'b0;
        data_v_i = 1'b0;
        #1;
        checks++;
        if (link_v_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: v=%0b busy=%0b required 0 0", link_v_o, busy_o);
        end
        repeat (2) @(posedge clk);
        #3 reset_n_i = 1'b1;
        @(negedge clk);
        checks++;
        if (pkt_ready_o !== 1'b1 || data_ready_o !== 1'b0 || link_v_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release: pkt_ready=%0b data_ready=%0b v=%0b required 1 0 0",
                     pkt_ready_o, data_ready_o, link_v_o);
        end
        n0 = n_rx;
        send_pkt(5'd6, 4'd1, 23'h44, 32'h600);
        wait_rx(n0 + 2, 50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_mid_recover: got %0d flits required 2", n_rx - n0);
        end
    endtask

    initial begin
        reset_n_i      = 1'b0;
        pkt_v_i        = 1'b0;
        pkt_cord_i     = '0;
        pkt_len_i      = '0;
        pkt_hdr_data_i = '0;
        data_v_i       = 1'b0;
        data_i         = '0;
        link_ready_i   = 1'b1;
        test_reset();
        test_basic();
        test_header_only();
        test_backpressure();
        test_back_to_back();
        test_max_len();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
